// File: rtl/inv_key_expansion_if.sv
// Request/response bundle of the inverse key schedule and the field/transform parameters.
// Element layout: 8 data bits (coefficient x^0 at the MSB) followed by d mask bits.
interface inv_key_expansion_if #(
  parameter int D = 4
);
  typedef logic [7+D:0]             state_elem_t;
  typedef state_elem_t [3:0][3:0]   state_vec_t;

  state_vec_t   in;
  logic         first_round;
  logic [0:7]   rc_last;
  logic [D-1:0] r;
  logic         drdy_i;
  state_vec_t   out;
  logic         drdy_o;

  modport master (
    output in, first_round, rc_last, r, drdy_i,
    input  out, drdy_o
  );

  modport slave (
    input  in, first_round, rc_last, r, drdy_i,
    output out, drdy_o
  );
endinterface

interface params_if;
  // L: row i of the input transform; P: reduction polynomial without x^8, bit i = coeff of x^i
  logic [0:7][0:7] L;
  logic [0:7]      P;

  modport in_use (input L, P);
  modport cfg    (output L, P);
endinterface

// File: rtl/inv_key_expansion.sv
// Inverse CLM key schedule: K_i -> K_{i-1}, drdy_i to drdy_o in 4+SBOX_LAT cycles.
// Requests outside KI_IDLE are dropped, not queued; out is held until the next transaction.
module inv_key_expansion #(
  parameter int D        = 4,
  parameter int SBOX_LAT = 2
) (
  input logic                clk,
  input logic                rst,
  inv_key_expansion_if.slave bus,
  params_if.in_use           params
);
  typedef logic [7+D:0] elem_t;
  typedef elem_t [3:0]  word_t;
  typedef enum logic [2:0] {KI_IDLE, PRE, SUB_WORD, XOR, OUT} state_e;

  state_e                 state_q, state_d;
  logic [0:7]             rc_q, rc_d;
  word_t                  w0_q, w0_d;
  word_t [3:1]            p_q, p_d;
  word_t                  sub_q, sub_d;
  elem_t [3:0][3:0]       out_q, out_d;

  word_t      w [4];
  word_t      rot;
  word_t      sbox_out;
  word_t      p0;
  logic [3:0] sbox_rdy;
  logic       sbox_go;
  logic [0:7] rc_prev;
  elem_t      rcon0;

  function automatic logic [0:7] input_transform(input logic [0:7] x, input logic [0:7][0:7] l);
    logic [0:7] y;
    for (int i = 0; i < 8; i++) begin
      y[i] = ^(l[i] & x);
    end
    return y;
  endfunction

  always_comb begin
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) begin
        w[c][k] = bus.in[k][c];
      end
    end
  end

  // Dividing rc by x undoes the forward xtime; needs P[0]=1.
  assign rc_prev = {rc_q[1:7] ^ ({7{rc_q[0]}} & params.P[1:7]), rc_q[0]};
  assign rcon0   = {input_transform(rc_q, params.L), {D{1'b0}}};

  always_comb begin
    p0    = w0_q ^ sub_q;
    p0[0] = p0[0] ^ rcon0;
  end

  for (genvar k = 0; k < 4; k++) begin : g_sbox
    assign rot[k] = p_q[3][(k + 1) % 4];

    clm_sbox #(
      .D   (D),
      .LAT (SBOX_LAT)
    ) u_sbox (
      .clk    (clk),
      .rst    (rst),
      .drdy_i (sbox_go),
      .in_i   (rot[k]),
      .r_i    (bus.r),
      .poly_i (params.P),
      .out_o  (sbox_out[k]),
      .drdy_o (sbox_rdy[k])
    );
  end

  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    w0_d    = w0_q;
    p_d     = p_q;
    sub_d   = sub_q;
    out_d   = out_q;
    sbox_go = 1'b0;
    case (state_q)
      KI_IDLE: begin
        if (bus.drdy_i) begin
          state_d = PRE;
          if (bus.first_round) begin
            rc_d = bus.rc_last;
          end
        end
      end
      PRE: begin
        w0_d    = w[0];
        p_d[3]  = w[3] ^ w[2];
        p_d[2]  = w[2] ^ w[1];
        p_d[1]  = w[1] ^ w[0];
        state_d = SUB_WORD;
      end
      SUB_WORD: begin
        sbox_go = 1'b1;
        if (&sbox_rdy) begin
          sub_d   = sbox_out;
          state_d = XOR;
        end
      end
      XOR: begin
        for (int k = 0; k < 4; k++) begin
          out_d[k][0] = p0[k];
          for (int c = 1; c < 4; c++) begin
            out_d[k][c] = p_q[c][k];
          end
        end
        rc_d    = rc_prev;
        state_d = OUT;
      end
      OUT: begin
        state_d = KI_IDLE;
      end
      default: begin
        state_d = KI_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= KI_IDLE;
      rc_q    <= '0;
      w0_q    <= '0;
      p_q     <= '0;
      sub_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      rc_q    <= rc_d;
      w0_q    <= w0_d;
      p_q     <= p_d;
      sub_q   <= sub_d;
      out_q   <= out_d;
    end
  end

  assign bus.out    = out_q;
  assign bus.drdy_o = (state_q == OUT);
endmodule

// Masked S-Box: element {x ^ expand(m), m}; output re-masked with fresh r.
// drdy_o rises after LAT cycles of continuous drdy_i and drops as soon as drdy_i drops.
module clm_sbox #(
  parameter int D   = 4,
  parameter int LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         drdy_i,
  input  logic [7+D:0] in_i,
  input  logic [D-1:0] r_i,
  input  logic [0:7]   poly_i,
  output logic [7+D:0] out_o,
  output logic         drdy_o
);
  localparam int            CW     = $clog2(LAT + 1);
  localparam logic [CW-1:0] LAT_C  = CW'(LAT);
  localparam logic [7:0]    AFF_C  = 8'h63;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [7+D:0]  out_q, out_d;
  logic [0:7]    x, y;

  function automatic logic [0:7] expand(input logic [D-1:0] m);
    logic [0:7] e;
    for (int i = 0; i < 8; i++) begin
      e[i] = m[i % D];
    end
    return e;
  endfunction

  function automatic logic [0:7] gf_mul(input logic [0:7] a, input logic [0:7] b,
                                        input logic [0:7] p);
    logic [0:7] acc;
    acc = '0;
    for (int i = 7; i >= 0; i--) begin
      acc = {1'b0, acc[0:6]} ^ (acc[7] ? p : 8'h00);
      if (b[i]) begin
        acc = acc ^ a;
      end
    end
    return acc;
  endfunction

  // x^254 = x^-1 for x != 0, and 0 maps to 0.
  function automatic logic [0:7] gf_inv(input logic [0:7] a, input logic [0:7] p);
    logic [0:7] sq, res;
    sq  = a;
    res = 8'h80;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq, p);
      res = gf_mul(res, sq, p);
    end
    return res;
  endfunction

  function automatic logic [0:7] affine(input logic [0:7] b);
    logic [0:7] s;
    for (int i = 0; i < 8; i++) begin
      s[i] = b[i] ^ b[(i + 4) % 8] ^ b[(i + 5) % 8] ^ b[(i + 6) % 8] ^ b[(i + 7) % 8]
             ^ AFF_C[i];
    end
    return s;
  endfunction

  always_comb begin
    x     = in_i[7+D:D] ^ expand(in_i[D-1:0]);
    y     = affine(gf_inv(x, poly_i));
    out_d = drdy_i ? {y ^ expand(r_i), r_i} : out_q;
    cnt_d = '0;
    if (drdy_i) begin
      cnt_d = (cnt_q == LAT_C) ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      out_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign out_o  = out_q;
  assign drdy_o = (cnt_q == LAT_C);
endmodule

// File: tb/tb_inv_key_expansion.sv
// Directed bench for inv_key_expansion using the FIPS-197 AES-128 key schedule as reference.
module tb_inv_key_expansion;
  localparam int D = 4;
  localparam int S = 2;

  typedef logic [7+D:0]      elem_t;
  typedef elem_t [3:0][3:0]  vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  bit   rand_r = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  inv_key_expansion_if #(.D(D)) bus();
  params_if pif();

  inv_key_expansion #(
    .D        (D),
    .SBOX_LAT (S)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .params (pif)
  );

  // FIPS-197 appendix A.1 round keys 0..10
  logic [127:0] rk [0:10];
  initial begin
    rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  end

  always @(negedge clk) bus.r = rand_r ? D'($urandom) : '0;

  function automatic logic [0:7] coef(input logic [7:0] b);
    logic [0:7] c;
    for (int i = 0; i < 8; i++) c[i] = b[i];
    return c;
  endfunction

  function automatic elem_t enc(input logic [7:0] b, input logic [D-1:0] m);
    logic [0:7] c;
    for (int i = 0; i < 8; i++) c[i] = b[i] ^ m[i % D];
    return {c, m};
  endfunction

  function automatic logic [7:0] dec(input elem_t e);
    logic [0:7]   c;
    logic [D-1:0] m;
    logic [7:0]   b;
    c = e[7+D:D];
    m = e[D-1:0];
    for (int i = 0; i < 8; i++) b[i] = c[i] ^ m[i % D];
    return b;
  endfunction

  function automatic vec_t pack_key(input logic [127:0] k, input bit masked);
    vec_t         v;
    logic [D-1:0] m;
    for (int n = 0; n < 16; n++) begin
      m = masked ? D'($urandom) : '0;
      v[n % 4][n / 4] = enc(k[127 - 8*n -: 8], m);
    end
    return v;
  endfunction

  function automatic logic [127:0] unpack_key(input vec_t v);
    logic [127:0] k;
    for (int n = 0; n < 16; n++) k[127 - 8*n -: 8] = dec(v[n % 4][n / 4]);
    return k;
  endfunction

  task automatic run_txn(input vec_t key, input bit fr, output int lat, output int pulses,
                         output vec_t res);
    lat = -1;
    pulses = 0;
    res = '0;
    @(negedge clk);
    bus.in = key;
    bus.first_round = fr;
    bus.drdy_i = 1'b1;
    @(negedge clk);
    bus.drdy_i = 1'b0;
    bus.first_round = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      if (bus.drdy_o === 1'b1) begin
        pulses++;
        if (lat < 0) begin
          lat = k;
          res = bus.out;
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.drdy_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (bus.out !== '0 || bus.drdy_o !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle cycle %0d: out=%h drdy_o=%b, want 0/0", i, bus.out, bus.drdy_o);
      end
    end
  endtask

  task automatic test_round10();
    int   lat, pulses;
    vec_t res;
    run_txn(pack_key(rk[10], 1'b0), 1'b1, lat, pulses, res);
    checks++;
    if (lat !== 4 + S) begin
      failures++;
      $display("FAIL r10_latency: got %0d want %0d", lat, 4 + S);
    end
    checks++;
    if (pulses !== 1) begin
      failures++;
      $display("FAIL r10_pulses: got %0d want 1", pulses);
    end
    checks++;
    if (res !== pack_key(rk[9], 1'b0)) begin
      failures++;
      $display("FAIL r10_out: got %h want %h", unpack_key(res), rk[9]);
    end
    checks++;
    if (bus.out !== pack_key(rk[9], 1'b0)) begin
      failures++;
      $display("FAIL r10_hold: got %h want %h", unpack_key(bus.out), rk[9]);
    end
  endtask

  task automatic test_chain();
    int   lat, pulses;
    vec_t key, res;
    key = pack_key(rk[10], 1'b0);
    for (int step = 0; step < 10; step++) begin
      run_txn(key, step == 0, lat, pulses, res);
      checks++;
      if (unpack_key(res) !== rk[9 - step] || pulses !== 1) begin
        failures++;
        $display("FAIL chain_round%0d: got %h (pulses %0d) want %h (pulses 1)",
                 9 - step, unpack_key(res), pulses, rk[9 - step]);
      end
      key = res;
    end
  endtask

  task automatic test_ignored_drdy();
    int lat, pulses;
    lat = -1;
    pulses = 0;
    @(negedge clk);
    bus.in = pack_key(rk[10], 1'b0);
    for (int k = 0; k < 40; k++) begin
      if (bus.drdy_o === 1'b1) begin
        pulses++;
        if (lat < 0) lat = k;
      end
      bus.first_round = (k == 0);
      bus.drdy_i = (k <= 2 + S) || (k == 4 + S);
      @(negedge clk);
    end
    bus.drdy_i = 1'b0;
    checks++;
    if (pulses !== 1 || lat !== 4 + S) begin
      failures++;
      $display("FAIL ignored_drdy: pulses=%0d lat=%0d, want 1 and %0d", pulses, lat, 4 + S);
    end
    checks++;
    if (bus.out !== pack_key(rk[9], 1'b0)) begin
      failures++;
      $display("FAIL ignored_drdy_out: got %h want %h", unpack_key(bus.out), rk[9]);
    end
  endtask

  task automatic test_masked();
    int   lat, pulses;
    vec_t res;
    rand_r = 1'b1;
    for (int it = 0; it < 3; it++) begin
      run_txn(pack_key(rk[10], 1'b1), 1'b1, lat, pulses, res);
      checks++;
      if (unpack_key(res) !== rk[9] || lat !== 4 + S) begin
        failures++;
        $display("FAIL masked_r9 iter %0d: got %h lat %0d want %h lat %0d",
                 it, unpack_key(res), lat, rk[9], 4 + S);
      end
      run_txn(res, 1'b0, lat, pulses, res);
      checks++;
      if (unpack_key(res) !== rk[8]) begin
        failures++;
        $display("FAIL masked_r8 iter %0d: got %h want %h", it, unpack_key(res), rk[8]);
      end
    end
    rand_r = 1'b0;
  endtask

  task automatic test_reset_mid();
    int   lat, pulses;
    vec_t res;
    @(negedge clk);
    bus.in = pack_key(rk[10], 1'b0);
    bus.first_round = 1'b1;
    bus.drdy_i = 1'b1;
    @(negedge clk);
    bus.drdy_i = 1'b0;
    bus.first_round = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checks++;
    if (bus.out !== '0 || bus.drdy_o !== 1'b0) begin
      failures++;
      $display("FAIL midreset_state: out=%h drdy_o=%b want 0/0", bus.out, bus.drdy_o);
    end
    pulses = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (bus.drdy_o === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      failures++;
      $display("FAIL midreset_no_pulse: got %0d pulses want 0", pulses);
    end
    run_txn(pack_key(rk[10], 1'b0), 1'b1, lat, pulses, res);
    checks++;
    if (unpack_key(res) !== rk[9] || lat !== 4 + S) begin
      failures++;
      $display("FAIL midreset_recover: got %h lat %0d want %h lat %0d",
               unpack_key(res), lat, rk[9], 4 + S);
    end
  endtask

  initial begin
    bus.in = '0;
    bus.first_round = 1'b0;
    bus.rc_last = coef(8'h36);
    bus.drdy_i = 1'b0;
    pif.P = coef(8'h1b);
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) pif.L[i][j] = (i == j);
    end
    test_reset();
    test_round10();
    test_chain();
    test_ignored_drdy();
    test_masked();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
